serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder sequencer: time-shares one 1-bit full-adder cell across WIDTH cycles.
//  Operands are added LSB-first; a carry flip-flop links successive bits.
//  Sits between a register-file/ALU front end and the gate-level full-adder datapath.
//  Trades area (one FA cell) for latency (WIDTH+1 cycles).
// PARAMETERS
//  WIDTH   8   operand/result width in bits; must be >= 1
// PORTS
//  clk    in   1      single clock; all state updates on the rising edge
//  rst    in   1      asynchronous reset, active-high
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A; captured on accepted start
//  b      in   WIDTH  operand B; captured on accepted start
//  cin    in   1      carry-in; captured on accepted start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse in DONE
//  sum    out  WIDTH  result; held stable from done until next accepted start
//  cout   out  1      final carry; held like sum
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; carry FF=0; bit counter=0.
//  FSM states: IDLE(2'b00), RUN(2'b01), DONE(2'b10); 2'b11 is illegal and recovers to IDLE.
//  IDLE->RUN on start=1: capture a, b into shift regs, carry FF<=cin, counter<=0, sum<=0.
//  RUN, each cycle:
//   - FA cell inputs: (a_sh[0], b_sh[0], carry).
//   - FA sum is shifted into sum MSB; a_sh/b_sh shift right; carry<=FA carry; counter++.
//  RUN->DONE when counter==WIDTH-1 at that edge (exactly WIDTH RUN cycles); cout<=final carry.
//  DONE: done=1 for exactly one cycle.
//   - start=1 goes directly to RUN with new operands (back-to-back); otherwise go to IDLE.
//  Latency: start accepted at edge 0 -> done high in cycle WIDTH+1.
//   - Back-to-back throughput: one result per WIDTH+1 cycles.
//  start during RUN: ignored; no queueing; the current operation is unaffected.
//  Operand changes on a/b/cin after capture: no effect.
//  sum and cout update only at final-bit completion and are never visible mid-operation.
//   - Hold a separate shadow; publish at RUN->DONE.
//  Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
//  WIDTH=1: RUN lasts one cycle.
//  Reset mid-RUN: operation abandoned; no done pulse; outputs return to reset values.
// CONFIGURATION
//  Macro SERIAL_ADDER_SUB_EN:
//  Defined:
//   - Adds input port `sub` (1 bit), captured with start.
//   - sub=1: B shift reg loads ~b, carry FF loads 1 (cin ignored); result = a - b.
//   - sub=1: cout=1 means no borrow.
//   - sub=0: add, identical to the undefined case.
//  Undefined: no `sub` port; add-only; logic fully removed.
// STRUCTURE
//  Shared header serial_adder_defs.vh:
//   - `define state encodings (IDLE/RUN/DONE, 2-bit).
//   - State-width constant.
//  Counter width = $clog2(WIDTH) (min 1), local to this module.
//  One sub-module: fa_cell (1-bit full adder: sum = a^b^c, carry = majority), built from XOR/AND/OR gates.
//  Controller (FSM, counter, shift regs, carry FF) lives in serial_adder_ctrl.
// TESTING (WIDTH=8)
//  1. a=8'h3C, b=8'h0F, cin=0, start pulse -> busy 8 cycles; done in cycle 9; sum=8'h4B, cout=0.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//     a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  3. start held high through DONE with new operands 8'h01+8'h02 -> second RUN starts next cycle.
//     Second done in 9 cycles; sum=8'h03.
//  4. start re-pulsed with a=8'h00 during RUN -> ignored; first result is unchanged.
//  5. rst asserted at RUN cycle 4 -> immediate busy=0, sum=0, cout=0; no done pulse.
//     Next start completes normally.
//  6. SERIAL_ADDER_SUB_EN: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0.
//     sub=1, a=8'h07, b=8'h05 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// State encodings are fixed: Idle=00, Run=01, Done=10; 11 is unused and recovers to Idle.
package serial_adder_ctrl_pkg;

  localparam int unsigned StateWidth = 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between the front end and the serial adder.
// The optional subtract port is present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/fa_cell.sv
// Gate-level 1-bit full adder: sum = a^b^c, carry = majority(a, b, c).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ c;
  assign carry = (a & b) | (p & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one fa_cell reused LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the `sub` request bit (a - b via ~b and carry-in 1).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CntW-1:0]  cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load     = bus.sub ? ~bus.b : bus.b;
    carry_load = bus.sub ? 1'b1 : bus.cin;
  end
`else
  always_comb begin
    b_load     = bus.b;
    carry_load = bus.cin;
  end
`endif

  fa_cell u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New result bit enters at the MSB so the LSB-first stream lands in order.
  if (WIDTH == 1) begin : g_w1
    assign sum_next = fa_sum;
  end else begin : g_wn
    assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state    <= StRun;
            bus.busy <= 1'b1;
            a_sh     <= bus.a;
            b_sh     <= b_load;
            carry    <= carry_load;
            sum_sh   <= '0;
            cnt      <= '0;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_carry;
          cnt    <= cnt + CntW'(1);
          // Results are published only here, so the outputs never show partial sums.
          if (cnt == LastBit) begin
            state    <= StDone;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.sum  <= sum_next;
            bus.cout <= fa_carry;
          end
        end
        default: begin
          state    <= StIdle;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed spec cases plus random traffic
// against a transaction-level timing/arithmetic model.
module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op accepted at edge k shows busy after edges k..k+W-1, done after edge k+W,
  // and its arithmetic result is held from edge k+W onward.
  int unsigned edge_n = 0;
  int unsigned acc    = 0;
  bit          act    = 1'b0;
  logic [W:0]  exp_r  = '0;
  logic [W:0]  held   = '0;
  bit          chk_on = 1'b0;

  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  always @(posedge clk) begin
    logic s;
    s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    s = bus.sub;
`endif
    if (rst) begin
      act  = 1'b0;
      held = '0;
    end else begin
      edge_n++;
      if (act && edge_n == acc + W) held = exp_r;
      if (act && edge_n > acc + W) act = 1'b0;
      if (!act && bus.start) begin
        act   = 1'b1;
        acc   = edge_n;
        exp_r = ref_result(bus.a, bus.b, bus.cin, s);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (rst) begin
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_result", {23'b0, bus.cout, bus.sum}, 0);
      end else begin
        logic eb, ed;
        eb = act && (edge_n < acc + W);
        ed = act && (edge_n == acc + W);
        chk("busy", {31'b0, bus.busy}, {31'b0, eb});
        chk("done", {31'b0, bus.done}, {31'b0, ed});
        if (!eb) chk("result", {23'b0, bus.cout, bus.sum}, {23'b0, held});
      end
    end
  end

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sub;
`else
    if (sub) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // Waits (bounded) for done; n counts cycles since the accepting edge.
  task automatic wait_done(input string name, input int start_n, output int n, output bit ok);
    n = start_n;
    while (!bus.done && n < 3 * W) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = bus.done;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, done not seen after %0d cycles, expected by %0d", name, n, W + 1);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [W:0] exp);
    int n;
    bit ok;
    @(negedge clk);
    #1;
    drive(1'b1, a, b, cin, sub);
    @(negedge clk);
    #1;
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    wait_done(name, 1, n, ok);
    if (ok) begin
      chk({name, "_latency"}, n, W + 1);
      chk({name, "_result"}, {23'b0, bus.cout, bus.sum}, {23'b0, exp});
    end
  endtask

  initial begin
    int n;
    bit ok;
    int done_seen;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", {31'b0, bus.busy}, 0);
    chk("reset_result", {23'b0, bus.cout, bus.sum}, 0);
    rst = 1'b0;

    run_op("t1", 8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B);
    chk("model_pin", {23'b0, held}, 32'h04B);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
    chk("model_pin2", {23'b0, ref_result(8'h80, 8'h80, 1'b1, 1'b0)}, 32'h101);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    #1;
    drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    wait_done("t3a", 1, n, ok);
    if (ok) chk("t3a_result", {23'b0, bus.cout, bus.sum}, 32'h030);
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    drive(1'b0, 8'hAA, 8'hBB, 1'b1, 1'b0);
    chk("t3_busy_next", {31'b0, bus.busy}, 1);
    wait_done("t3b", 1, n, ok);
    if (ok) begin
      chk("t3b_latency", n, W + 1);
      chk("t3b_result", {23'b0, bus.cout, bus.sum}, 32'h003);
    end

    // start re-pulsed during RUN is ignored.
    @(negedge clk);
    #1;
    drive(1'b1, 8'h55, 8'h2A, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done("t4", 4, n, ok);
    if (ok) begin
      chk("t4_latency", n, W + 1);
      chk("t4_result", {23'b0, bus.cout, bus.sum}, 32'h07F);
    end

    // Reset mid-RUN.
    @(negedge clk);
    #1;
    drive(1'b1, 8'h77, 8'h11, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", {31'b0, bus.busy}, 0);
    chk("t5_result", {23'b0, bus.cout, bus.sum}, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    done_seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("t5_no_done", done_seen, 0);
    run_op("t5_after", 8'h12, 8'h34, 1'b1, 1'b0, 9'h047);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("t6a", 8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE);
    run_op("t6b", 8'h07, 8'h05, 1'b0, 1'b1, 9'h102);
    run_op("t6c", 8'h05, 8'h07, 1'b1, 1'b0, 9'h00D);
`endif

    // Random traffic with occasional async reset; the compare process checks every cycle.
    repeat (3000) begin
      @(negedge clk);
      #1;
      drive(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom), 1'($urandom),
            1'($urandom));
      rst = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
